// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer: opcodes, FSM
// state encodings and default latencies.
package mdu_sequencer_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// Combinational MDU datapath: 64-bit product, or {remainder, quotient} for
// divides, plus a divide-by-zero flag.
module mdu_arith
    import mdu_sequencer_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic        signed_op;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    assign signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);

    // Low 64 bits of a 64x64 product are correct for both sign modes.
    assign a_ext = signed_op ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    assign b_ext = signed_op ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    assign prod  = a_ext * b_ext;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000, rem 0.
    assign a_neg  = signed_op & a_i[31];
    assign b_neg  = signed_op & b_i[31];
    assign a_mag  = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag  = b_neg ? (32'd0 - b_i) : b_i;
    assign b_safe = (b_i == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    assign result_o   = is_div_op(op_i) ? {rem, quo} : prod;
    assign div_zero_o = is_div_op(op_i) && (b_i == 32'd0);

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer owning HI/LO with fixed-latency busy timing.
// Optional macro MDU_CANCEL_EN adds a Cancel input that kills a same-cycle Start.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUType,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        dz_q, dz_d;
    logic        accept;
    logic [63:0] arith_res;
    logic        arith_dz;

    mdu_arith u_arith (
        .op_i       (MDUType),
        .a_i        (A),
        .b_i        (B),
        .result_o   (arith_res),
        .div_zero_o (arith_dz)
    );

`ifdef MDU_CANCEL_EN
    assign accept = Start && (state_q == ST_IDLE) && !Cancel;
`else
    assign accept = Start && (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        dz_d      = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (MDUType)
                        MDU_MULT, MDU_MULTU: begin
                            pend_hi_d = arith_res[63:32];
                            pend_lo_d = arith_res[31:0];
                            dz_d      = 1'b0;
                            cnt_d     = 4'(MUL_CYCLES);
                            state_d   = ST_MUL;
                            busy_d    = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_hi_d = arith_res[63:32];
                            pend_lo_d = arith_res[31:0];
                            dz_d      = arith_dz;
                            cnt_d     = 4'(DIV_CYCLES);
                            state_d   = ST_DIV;
                            busy_d    = 1'b1;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        Out = 32'd0;
        if (MDUType == MDU_MFHI)      Out = hi_q;
        else if (MDUType == MDU_MFLO) Out = lo_q;
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus random ops checked
// against an arithmetic reference model of HI/LO and op latency.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUType;
    logic [31:0] A, B;
`ifdef MDU_CANCEL_EN
    logic        Cancel;
`endif
    logic        Busy;
    logic [31:0] HI, LO, Out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDUType (MDUType),
        .A       (A),
        .B       (B),
`ifdef MDU_CANCEL_EN
        .Cancel  (Cancel),
`endif
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .Out     (Out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int op_latency(input logic [3:0] op);
        if (op == MDU_MULT || op == MDU_MULTU) return 5;
        if (op == MDU_DIV  || op == MDU_DIVU)  return 10;
        return 0;
    endfunction

    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, sq, sr;
        logic [63:0] up;
        case (op)
            MDU_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MDU_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            MDU_DIV: if (b != 32'd0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            MDU_DIVU: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cancel);
        int n, exp_n;
        exp_n = cancel ? 0 : op_latency(op);
        @(negedge clk);
        Start = 1'b1; MDUType = op; A = a; B = b;
`ifdef MDU_CANCEL_EN
        Cancel = cancel;
`endif
        @(negedge clk);
        Start = 1'b0; MDUType = MDU_MFLO; A = $urandom; B = $urandom;
`ifdef MDU_CANCEL_EN
        Cancel = 1'b0;
`endif
        #1;
        if (exp_n > 0) check_val("out_old_lo_while_busy", Out, m_lo);
        wait_idle(n);
        check_val("busy_len", 32'(n), 32'(exp_n));
        if (!cancel) model_apply(op, a, b);
        check_val("hi", HI, m_hi);
        check_val("lo", LO, m_lo);
        MDUType = MDU_MFHI; #1;
        check_val("out_mfhi", Out, m_hi);
        MDUType = MDU_NONE; #1;
        check_val("out_none", Out, 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        c;

        reset = 1'b0; Start = 1'b0; MDUType = MDU_NONE; A = 32'd0; B = 32'd0;
`ifdef MDU_CANCEL_EN
        Cancel = 1'b0;
`endif
        #12;
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_hi", HI, 32'd0);
        check_val("rst_lo", LO, 32'd0);
        @(negedge clk); reset = 1'b1;

        run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check_val("mult_neg_hi", HI, 32'hFFFF_FFFF);
        check_val("mult_neg_lo", LO, 32'hFFFF_FFFA);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check_val("multu_hi", HI, 32'd1);
        check_val("multu_lo", LO, 32'hFFFF_FFFE);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        check_val("div_neg_lo", LO, 32'hFFFF_FFFD);
        check_val("div_neg_hi", HI, 32'hFFFF_FFFF);
        run_op(MDU_DIVU,  32'd100, 32'd7, 1'b0);
        check_val("divu_lo", LO, 32'd14);
        check_val("divu_hi", HI, 32'd2);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("div_ovf_lo", LO, 32'h8000_0000);
        check_val("div_ovf_hi", HI, 32'd0);
        run_op(MDU_MTHI,  32'd5, 32'd0, 1'b0);
        run_op(MDU_MTLO,  32'd9, 32'd0, 1'b0);
        run_op(MDU_DIVU,  32'd1234, 32'd0, 1'b0);
        check_val("dz_hi", HI, 32'd5);
        check_val("dz_lo", LO, 32'd9);

        // Start during busy cycle 3 of a MULT must be ignored.
        @(negedge clk);
        Start = 1'b1; MDUType = MDU_MULT; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
        @(negedge clk); Start = 1'b0; MDUType = MDU_NONE;
        @(negedge clk);
        @(negedge clk); Start = 1'b1; MDUType = MDU_MTLO; A = 32'd1;
        @(negedge clk); Start = 1'b0; MDUType = MDU_NONE; #1;
        wait_idle(n);
        check_val("busy_start_len", 32'(n + 3), 32'd5);
        model_apply(MDU_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        check_val("busy_start_lo", LO, m_lo);
        check_val("busy_start_hi", HI, m_hi);

        // Reset pulse at busy cycle 2 of a DIV.
        @(negedge clk);
        Start = 1'b1; MDUType = MDU_DIV; A = 32'd77; B = 32'd5;
        @(negedge clk); Start = 1'b0; MDUType = MDU_NONE;
        @(negedge clk); reset = 1'b0; #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check_val("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check_val("mid_rst_hi", HI, 32'd0);
        check_val("mid_rst_lo", LO, 32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check_val("post_rst_busy", {31'd0, Busy}, 32'd0);
        check_val("post_rst_hi", HI, 32'd0);
        check_val("post_rst_lo", LO, 32'd0);

`ifdef MDU_CANCEL_EN
        run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        check_val("cancel_mthi_hi", HI, 32'd0);
        run_op(MDU_MULT, 32'd3, 32'd4, 1'b1);
`endif

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 8));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            c = 1'b0;
`ifdef MDU_CANCEL_EN
            c = ($urandom_range(0, 3) == 0);
`endif
            run_op(op, a, b, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
